// File: rtl/mult_div.sv
// Sequential 32x32 multiply / divide unit producing HI/LO results.
// Works on operand magnitudes one bit per cycle, then fixes signs in a single cycle.
module mult_div (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r, state_next_s;
  logic [5:0]  cnt_r;
  logic        is_div_r, neg_q_r, neg_r_r, dz_r;
  logic [31:0] oper_r, work_hi_r, work_lo_r, hi_r, lo_r;
  logic        busy_r, done_r, div_zero_r;

  logic        sign_op_s, a_neg_s, b_neg_s, b_zero_s, accept_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic [32:0] mul_sum_s, div_sh_s, div_diff_s;
  logic        div_ge_s;
  logic [31:0] step_hi_s, step_lo_s, fix_hi_s, fix_lo_s;
  logic [63:0] prod_neg_s;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  // Operand conditioning and start acceptance (a start is not taken while done is still showing).
  always_comb begin
    sign_op_s = ~mdop[0];
    a_neg_s   = sign_op_s & a[31];
    b_neg_s   = sign_op_s & b[31];
    mag_a_s   = a_neg_s ? neg32(a) : a;
    mag_b_s   = b_neg_s ? neg32(b) : b;
    b_zero_s  = (b == 32'd0);
    accept_s  = (state_r == IDLE) && start && !done_r;
  end

  // One shift-add or restoring shift-subtract iteration.
  always_comb begin
    mul_sum_s  = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, oper_r} : 33'd0);
    div_sh_s   = {work_hi_r, work_lo_r[31]};
    div_diff_s = div_sh_s - {1'b0, oper_r};
    // The shifted remainder is below twice the divisor, so bit 32 of the difference is the borrow.
    div_ge_s   = ~div_diff_s[32];
    if (is_div_r) begin
      step_hi_s = div_ge_s ? div_diff_s[31:0] : div_sh_s[31:0];
      step_lo_s = {work_lo_r[30:0], div_ge_s};
    end else begin
      step_hi_s = mul_sum_s[32:1];
      step_lo_s = {mul_sum_s[0], work_lo_r[31:1]};
    end
  end

  // Sign correction of the magnitude result.
  always_comb begin
    prod_neg_s = neg64({work_hi_r, work_lo_r});
    if (is_div_r) begin
      fix_lo_s = neg_q_r ? neg32(work_lo_r) : work_lo_r;
      fix_hi_s = neg_r_r ? neg32(work_hi_r) : work_hi_r;
    end else if (neg_q_r) begin
      fix_hi_s = prod_neg_s[63:32];
      fix_lo_s = prod_neg_s[31:0];
    end else begin
      fix_hi_s = work_hi_r;
      fix_lo_s = work_lo_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = (mdop[1] && b_zero_s) ? DONE : CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == 6'd31) begin
          state_next_s = FIX;
        end else begin
          state_next_s = CALC;
        end
      end
      FIX:     state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath, result registers and status outputs (outputs follow the state by one cycle).
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r      <= 6'd0;
      is_div_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      dz_r       <= 1'b0;
      oper_r     <= 32'd0;
      work_hi_r  <= 32'd0;
      work_lo_r  <= 32'd0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      busy_r     <= (state_r == CALC) || (state_r == FIX);
      done_r     <= (state_r == DONE);
      div_zero_r <= (state_r == DONE) && dz_r;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r     <= 6'd0;
            is_div_r  <= mdop[1];
            neg_q_r   <= a_neg_s ^ b_neg_s;
            neg_r_r   <= a_neg_s;
            dz_r      <= mdop[1] && b_zero_s;
            oper_r    <= mdop[1] ? mag_b_s : mag_a_s;
            work_hi_r <= 32'd0;
            work_lo_r <= mdop[1] ? mag_a_s : mag_b_s;
          end
        end
        CALC: begin
          work_hi_r <= step_hi_s;
          work_lo_r <= step_lo_s;
          cnt_r     <= cnt_r + 6'd1;
        end
        FIX: begin
          hi_r <= fix_hi_s;
          lo_r <= fix_lo_s;
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign div_zero = div_zero_r;
  assign hi       = hi_r;
  assign lo       = lo_r;

endmodule

// File: tb/tb_mult_div.sv
// Directed, table-driven bench for mult_div: results, latency, busy length,
// divide-by-zero, ignored start, operand latching and reset behaviour.
module tb_mult_div;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [1:0]  mdop;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int tests_run = 0;
  int tests_failed = 0;

  mult_div dut (
    .clock(clock), .reset(reset), .start(start), .mdop(mdop), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] av, bv, exp_hi, exp_lo;
    logic        exp_dz;
    int          exp_lat;
    int          exp_busy;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one operation and watches 45 edges after the start edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input int poke_at, input int rst_at,
                        output logic [31:0] h, output logic [31:0] l, output logic dz,
                        output int lat, output int busy_n, output int pulses,
                        output int dz_bad, output logic busy_after_rst);
    @(negedge clock);
    mdop = op; a = av; b = bv; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0; mdop = 2'b10; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    lat = -1; busy_n = 0; pulses = 0; dz = 1'b0; dz_bad = 0; busy_after_rst = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(posedge clock);
      #1;
      if (busy) busy_n++;
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = i;
          dz  = div_zero;
        end
      end else if (div_zero) begin
        dz_bad++;
      end
      if (i == rst_at + 1) busy_after_rst = busy;
      start = (i == poke_at);
      if (i == poke_at) begin
        mdop = 2'b00; a = 32'd2; b = 32'd2;
      end
      reset = (i == rst_at);
    end
    start = 1'b0;
    reset = 1'b0;
    h = hi;
    l = lo;
  endtask

  logic [31:0] r_hi, r_lo;
  logic        r_dz, r_bar;
  int          r_lat, r_busy, r_pulses, r_dzbad, seen;

  initial begin
    vecs[0]  = '{"mult_7_m3",    2'b00, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 33};
    vecs[1]  = '{"multu_max",    2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 33};
    vecs[2]  = '{"div_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 33};
    vecs[3]  = '{"divu_100_7",   2'b11, 32'd100,        32'd7,         32'd2,         32'd14,        1'b0, 34, 33};
    vecs[4]  = '{"div_min_m1",   2'b10, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 34, 33};
    vecs[5]  = '{"mult_3_5",     2'b00, 32'd3,          32'd5,         32'd0,         32'd15,        1'b0, 34, 33};
    vecs[6]  = '{"divu_by_zero", 2'b11, 32'd5,          32'd0,         32'd0,         32'd15,        1'b1, 1,  0};
    vecs[7]  = '{"mult_zero",    2'b00, 32'd0,          32'd12345,     32'd0,         32'd0,         1'b0, 34, 33};
    vecs[8]  = '{"mult_min_min", 2'b00, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, 34, 33};
    vecs[9]  = '{"div_m100_7",   2'b10, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0, 34, 33};
    vecs[10] = '{"div_100_m7",   2'b10, 32'd100,        32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 1'b0, 34, 33};
    vecs[11] = '{"divu_max_1",   2'b11, 32'hFFFF_FFFF,  32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0, 34, 33};

    reset = 1'b1; start = 1'b0; mdop = 2'b00; a = 32'd0; b = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {busy, done, div_zero, hi, lo}, 67'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].av, vecs[i].bv, 0, -5,
             r_hi, r_lo, r_dz, r_lat, r_busy, r_pulses, r_dzbad, r_bar);
      check({vecs[i].name, "_hi"},      r_hi, vecs[i].exp_hi);
      check({vecs[i].name, "_lo"},      r_lo, vecs[i].exp_lo);
      check({vecs[i].name, "_dz"},      r_dz, vecs[i].exp_dz);
      check({vecs[i].name, "_latency"}, r_lat, vecs[i].exp_lat);
      check({vecs[i].name, "_busy"},    r_busy, vecs[i].exp_busy);
      check({vecs[i].name, "_pulses"},  r_pulses, 1);
      check({vecs[i].name, "_dz_idle"}, r_dzbad, 0);
    end

    // A start pulse during CALC must be ignored.
    run_op(2'b00, 32'd9, 32'd9, 5, -5, r_hi, r_lo, r_dz, r_lat, r_busy, r_pulses, r_dzbad, r_bar);
    check("ignored_start_lo", {r_hi, r_lo}, 64'd81);
    check("ignored_start_lat", r_lat, 34);
    check("ignored_start_pulses", r_pulses, 1);

    // Reset asserted in CALC cycle 10 aborts without a done pulse and clears HI/LO.
    run_op(2'b00, 32'd6, 32'd7, 0, 10, r_hi, r_lo, r_dz, r_lat, r_busy, r_pulses, r_dzbad, r_bar);
    check("abort_busy_next", r_bar, 1'b0);
    check("abort_pulses", r_pulses, 0);
    check("abort_busy_cycles", r_busy, 10);
    check("abort_hilo", {r_hi, r_lo}, 64'd0);

    // Reset has priority over start at the same edge.
    @(negedge clock);
    reset = 1'b1; start = 1'b1; mdop = 2'b01; a = 32'd3; b = 32'd3;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (busy || done) seen++;
    end
    check("reset_priority", seen, 0);
    check("reset_priority_hilo", {hi, lo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
